// File: rtl/io_map_pkg.sv
// io_map_pkg: shared IO register map, event bit positions and reader state encoding
package io_map_pkg;
  localparam logic [1:0] IOF_STATUS = 2'd0;
  localparam logic [1:0] IOF_DATA   = 2'd1;
  localparam logic [1:0] IOF_COUNT  = 2'd2;
  localparam logic [1:0] IOF_POS    = 2'd3;
  localparam int EV_LEFT   = 0;
  localparam int EV_ROT    = 1;
  localparam int EV_PUSH   = 2;
  localparam int EV_WEST   = 3;
  localparam int EV_SOUTH  = 4;
  localparam int EV_EAST   = 5;
  localparam int EV_NORTH  = 6;
  localparam int EV_CENTER = 7;
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/rotary_accumulator.sv
// rotary_accumulator: wrapping rotary position and saturating consumed-event count
// ports: clk, rst, pop (consume strobe), rot/left (event bits of consumed byte), pos, cnt
module rotary_accumulator #(
  parameter int POS_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pop,
  input  logic                 rot,
  input  logic                 left,
  output logic [POS_WIDTH-1:0] pos,
  output logic [CNT_WIDTH-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
      cnt <= '0;
    end else if (pop) begin
      if (~&cnt) cnt <= cnt + CNT_WIDTH'(1);
      if (rot) pos <= left ? pos - POS_WIDTH'(1) : pos + POS_WIDTH'(1);
    end
  end
endmodule

// File: rtl/io_fifo_reader.sv
// io_fifo_reader: pops event FIFO into a holding register exposed as CPU IO registers
// ports: clk, rst; FIFO side fifo_rd_en/fifo_dout/fifo_empty; CPU side rd_req/rd_addr/rd_data
module io_fifo_reader
  import io_map_pkg::*;
#(
  parameter int POS_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        rd_req,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data
);
  state_t state, state_nx;
  logic [7:0] hold;
  logic valid, pop;
  logic [POS_WIDTH-1:0] pos;
  logic [CNT_WIDTH-1:0] cnt;
  // hold is only meaningful in FULL; FETCH reports not-valid while the byte is in flight
  assign valid = state == S_FULL;
  always_comb begin
    pop = rd_req && rd_addr == IOF_DATA;
    fifo_rd_en = !fifo_empty && (state == S_EMPTY || (state == S_FULL && pop));
    state_nx = state == S_FETCH ? S_FULL :
               fifo_rd_en ? S_FETCH :
               (state == S_FULL && pop) ? S_EMPTY : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_EMPTY;
      hold    <= '0;
      rd_data <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH) hold <= fifo_dout;
      if (rd_req)
        rd_data <= rd_addr == IOF_STATUS ? {30'b0, state == S_FETCH, valid} :
                   rd_addr == IOF_DATA   ? (valid ? {24'b0, hold} : 32'b0) :
                   rd_addr == IOF_COUNT  ? 32'(cnt) : 32'($signed(pos));
    end
  end
  rotary_accumulator #(
    .POS_WIDTH(POS_WIDTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) u_acc (
    .clk (clk),
    .rst (rst),
    .pop (pop && valid),
    .rot (hold[EV_ROT]),
    .left(hold[EV_LEFT]),
    .pos (pos),
    .cnt (cnt)
  );
endmodule

// File: tb/tb_io_fifo_reader.sv
// tb_io_fifo_reader: directed and randomized checks of io_fifo_reader against a FIFO/register model
module tb_io_fifo_reader;
  localparam int PW = 8;
  localparam int CW = 9;
  logic clk = 0, rst = 1, fifo_rd_en, fifo_empty = 1, rd_req = 0;
  logic [7:0] fifo_dout = 0;
  logic [1:0] rd_addr = 0;
  logic [31:0] rd_data, d;
  int total = 0, bad = 0, pulses = 0, b2b = 0, p0, b0, mcnt, mpos, quiet, q0;
  logic prev_en = 0;
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] b;
  io_fifo_reader #(.POS_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    prev_en <= fifo_rd_en;
    if (fifo_rd_en) pulses <= pulses + 1;
    if (fifo_rd_en && prev_en) b2b <= b2b + 1;
    if (rst) begin
      fq.delete();
      fifo_empty <= 1;
      fifo_dout <= 0;
    end else if (fifo_rd_en && fq.size() != 0) begin
      fifo_empty <= fq.size() == 1;
      fifo_dout <= fq.pop_front();
    end
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    rd_req = 1;
    rd_addr = a;
    @(negedge clk);
    v = rd_data;
    rd_req = 0;
  endtask
  task automatic push(logic [7:0] v);
    fq.push_back(v);
    fifo_empty = 0;
  endtask
  task automatic do_reset;
    rst = 1;
    idle(2);
    rst = 0;
  endtask
  task automatic pop_one(input logic [7:0] v, output logic [31:0] r);
    push(v);
    idle(2);
    rd(2'd1, r);
  endtask
  function automatic logic [31:0] sext_pos(int p);
    logic [PW-1:0] w;
    w = PW'(p);
    return {{(32-PW){w[PW-1]}}, w};
  endfunction
  initial begin
    @(negedge clk);
    idle(2);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
    rst = 0;
    p0 = pulses;
    idle(5);
    chk("idle_rd_en", 32'(pulses - p0), 32'd0);
    rd(2'd0, d); chk("idle_status", d, 32'h0);
    rd(2'd1, d); chk("idle_data", d, 32'h0);
    rd(2'd2, d); chk("idle_count", d, 32'h0);
    p0 = pulses;
    push(8'h82);
    idle(1);
    rd(2'd0, d); chk("t2_status_fetch", d, 32'h2);
    rd(2'd0, d); chk("t2_status_valid", d, 32'h1);
    rd(2'd1, d); chk("t2_data", d, 32'h82);
    rd(2'd2, d); chk("t2_count", d, 32'h1);
    rd(2'd3, d); chk("t2_pos", d, 32'h1);
    chk("t2_pulses", 32'(pulses - p0), 32'd1);
    do_reset;
    p0 = pulses;
    b0 = b2b;
    repeat (3) push(8'h03);
    idle(2);
    rd(2'd1, d); chk("t3_data0", d, 32'h3);
    idle(1);
    rd(2'd1, d); chk("t3_data1", d, 32'h3);
    idle(1);
    rd(2'd1, d); chk("t3_data2", d, 32'h3);
    rd(2'd3, d); chk("t3_pos", d, 32'hFFFFFFFD);
    chk("t3_pulses", 32'(pulses - p0), 32'd3);
    chk("t3_b2b", 32'(b2b - b0), 32'd0);
    do_reset;
    push(8'h80);
    push(8'h81);
    idle(2);
    rd_req = 1;
    rd_addr = 2'd1;
    #1 chk("t4_rden_in_pop", 32'(fifo_rd_en), 32'h1);
    @(negedge clk);
    chk("t4_data0", rd_data, 32'h80);
    rd_req = 0;
    rd(2'd0, d); chk("t4_status_fetch", d, 32'h2);
    rd(2'd1, d); chk("t4_data1", d, 32'h81);
    rd(2'd0, d); chk("t4_status_empty", d, 32'h0);
    rd(2'd2, d); chk("t4_count", d, 32'h2);
    do_reset;
    for (int i = 0; i < (1 << (PW - 1)) - 1; i++) pop_one(8'h82, d);
    rd(2'd3, d); chk("t5_pos_max", d, 32'((1 << (PW - 1)) - 1));
    pop_one(8'h82, d);
    rd(2'd3, d); chk("t5_pos_wrap", d, sext_pos(1 << (PW - 1)));
    for (int i = 0; i < (1 << CW) - 1 - (1 << (PW - 1)); i++) pop_one(8'h80, d);
    rd(2'd2, d); chk("t5_count_top", d, 32'((1 << CW) - 1));
    repeat (3) pop_one(8'h80, d);
    rd(2'd2, d); chk("t5_count_sat", d, 32'((1 << CW) - 1));
    rd(2'd3, d); chk("t5_pos_kept", d, sext_pos(1 << (PW - 1)));
    do_reset;
    p0 = pulses;
    push(8'h42);
    idle(1);
    rst = 1;
    idle(1);
    rst = 0;
    idle(3);
    chk("t6_pulses", 32'(pulses - p0), 32'd1);
    rd(2'd0, d); chk("t6_status", d, 32'h0);
    rd(2'd1, d); chk("t6_data", d, 32'h0);
    rd(2'd2, d); chk("t6_count", d, 32'h0);
    rd(2'd3, d); chk("t6_pos", d, 32'h0);
    do_reset;
    mcnt = 0;
    mpos = 0;
    quiet = 10;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2 && mq.size() < 6) begin
        b = 8'($urandom) | 8'h80;
        push(b);
        mq.push_back(b);
        quiet = 0;
      end else if (r < 4) begin
        int n;
        n = int'($urandom_range(1, 4));
        idle(n);
        quiet += n;
      end else begin
        logic [1:0] a;
        a = 2'($urandom_range(0, 3));
        q0 = quiet;
        rd(a, d);
        quiet = q0 + 1;
        if (a == 2'd1) begin
          if (d != 0) begin
            chk("rnd_data", d, mq.size() != 0 ? {24'b0, mq[0]} : 32'h0);
            if (mq.size() != 0) begin
              b = mq.pop_front();
              if (mcnt < (1 << CW) - 1) mcnt++;
              if (b[1]) mpos += b[0] ? -1 : 1;
            end
            quiet = 0;
          end else if (mq.size() != 0 && q0 >= 2) chk("rnd_avail", d, {24'b0, mq[0]});
        end else if (a == 2'd0) begin
          if (q0 >= 2) chk("rnd_status", d, mq.size() != 0 ? 32'h1 : 32'h0);
        end else if (a == 2'd2) chk("rnd_count", d, 32'(mcnt));
        else chk("rnd_pos", d, sext_pos(mpos));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_fifo_reader.md
Name: io_fifo_reader

Overview:
CPU-side consumer of the 8-bit button/rotary event FIFO. It pops entries from the FIFO into a one-entry holding register and exposes them to the Riscv151 memory-mapped IO space as word-readable registers:
- status
- data (reading it consumes the entry)
- consumed-event count
- signed rotary position accumulated from consumed entries

It sits between the FIFO read port and the CPU IO load path.

Parameters:
- POS_WIDTH, 16, width of the rotary position accumulator (two's complement, wraps)
- CNT_WIDTH, 16, width of the consumed-event counter (saturates)

Ports:
- clk  in  1  CPU clock
- rst  in  1  reset; synchronous and active-high
- fifo_rd_en  out  1  FIFO pop strobe; FIFO dout is valid the cycle after rd_en
- fifo_dout  in  8  FIFO read data: {center,north,east,south,west,rotary_push,rotary_event,rotary_left}
- fifo_empty  in  1  FIFO empty flag
- rd_req  in  1  CPU IO load strobe for this block
- rd_addr  in  2  register select: 0 STATUS, 1 DATA, 2 COUNT, 3 POSITION
- rd_data  out  32  registered read data, valid the cycle after rd_req

Behaviour:
Reset values:
- fifo_rd_en=0, rd_data=0.
- hold register=0, hold valid=0.
- count=0, position=0.
- State EMPTY.

State machine (EMPTY, FETCH, FULL):
- EMPTY:
  - If !fifo_empty: fifo_rd_en=1 (combinational this cycle), next state FETCH.
  - Otherwise stay in EMPTY.
- FETCH:
  - Capture fifo_dout into hold, set valid=1, next state FULL.
  - fifo_rd_en=0.
- FULL: waits for a pop. A pop is rd_req && rd_addr==1.
  - On pop with !fifo_empty: fifo_rd_en=1 in the same cycle, next state FETCH.
  - On pop with fifo_empty: valid=0, next state EMPTY.
- fifo_rd_en is never asserted in FETCH or FULL-without-pop, so at most one outstanding FIFO read exists.
- Minimum pop-to-valid turnaround is 2 cycles. A CPU polling STATUS sees valid=0 during FETCH.

Register reads (rd_data is registered; it reflects state sampled in the rd_req cycle, before that cycle's updates):
- STATUS: {30'b0, state==FETCH, valid}.
- DATA: {24'b0, hold} if valid, else 32'b0.
- COUNT: zero-extended count.
- POSITION: sign-extended position.
- rd_data holds its last value when rd_req=0.

Pop side effects (only when valid=1 at the pop; a pop with valid=0 has no effect):
- count increments, saturating at 2^CNT_WIDTH-1.
- If hold[1] (rotary_event) is set: position += hold[0] ? -1 : +1, wrapping modulo 2^POS_WIDTH.

Boundary cases:
- Pop of DATA while in EMPTY or FETCH returns 0 and changes nothing.
- Reads of STATUS, COUNT and POSITION never pop.
- FIFO becomes non-empty in the same cycle as a FULL pop: the fifo_empty value sampled that cycle decides the transition.
- rst asserted mid-FETCH: the in-flight byte is discarded. The FIFO shares rst, so there is no stale data.
- rst has priority over all other inputs.

Decomposition:
- Shared package io_map_pkg holds:
  - register address constants (IOF_STATUS=0, IOF_DATA=1, IOF_COUNT=2, IOF_POS=3)
  - event bit indices (EV_LEFT=0, EV_ROT=1, EV_PUSH=2, EV_WEST=3, EV_SOUTH=4, EV_EAST=5, EV_NORTH=6, EV_CENTER=7)
  - state encoding
- One natural sub-module: rotary_accumulator (position register plus saturating counter, driven by a pop strobe and the event byte).

Test Plan:
1. Reset then idle with fifo_empty=1 → fifo_rd_en never asserts; STATUS read returns 0; DATA read returns 0 and COUNT stays 0.
2. Fifo model preloaded with 8'h82 (center + rotary_event, right) → rd_en pulses once; STATUS returns 1 by the second cycle; DATA read returns 32'h82; then COUNT=1 and POSITION=1.
3. Entries 8'h03, 8'h03, 8'h03 (left rotations) popped back-to-back at the earliest legal cycles → exactly three rd_en pulses, never two in consecutive cycles; POSITION reads 32'hFFFFFFFD.
4. Pop with FIFO non-empty in the same cycle → rd_en is asserted in the pop cycle; the next entry is valid 2 cycles later. Pop with FIFO empty → STATUS=0 afterwards.
5. POSITION preset to 16'h7FFF via 32767 right events, then one more right event → POSITION reads 32'hFFFF8000 (wrap). 65536 non-rotary pops → COUNT saturates at 32'h0000FFFF.
6. rst asserted during FETCH with fifo_dout=8'h42 → after release valid=0, count=0, position=0, and no stale 8'h42 is ever returned.
